// File: rtl/shr_iter.sv
// ============================================================================
// shr_iter : multi-cycle logical/arithmetic right shifter, coarse + 1-bit steps
// Rev 1.0
// ============================================================================
`default_nettype none

module shr_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               arith_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);
  localparam logic [SHAMT_W-1:0] ONE_C  = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               fill_q, fill_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      fill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      result_q <= result_d;
      count_q  <= count_d;
      fill_q   <= fill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    result_d = result_q;
    count_d  = count_q;
    fill_d   = fill_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && !flush_i) begin
          data_d  = a_i;
          count_d = shamt_i;
          fill_d  = arith_i & a_i[WIDTH-1];
          if (shamt_i == '0) begin
            state_d  = DONE;
            result_d = a_i;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          // Coarse steps first, then single bits for the remainder.
          if (count_q >= STEP_C) begin
            data_d  = {{STEP{fill_q}}, data_q[WIDTH-1:STEP]};
            count_d = count_q - STEP_C;
          end else begin
            data_d  = {fill_q, data_q[WIDTH-1:1]};
            count_d = count_q - ONE_C;
          end
          if (count_d == '0) begin
            state_d  = DONE;
            result_d = data_d;
          end
        end
      end
      DONE: begin
        if (flush_i || out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = result_q;

endmodule

`default_nettype wire
